// File: rtl/piece_spawn_if.sv
// Spawn-point collision-check handshake between the spawn controller (master) and the board (slave).
interface piece_spawn_if;
  logic       chk_req;
  logic [2:0] chk_piece;
  logic [3:0] chk_x;
  logic [4:0] chk_y;
  logic       chk_ack;
  logic       chk_collide;

  modport master (
    output chk_req, chk_piece, chk_x, chk_y,
    input  chk_ack, chk_collide
  );

  modport slave (
    input  chk_req, chk_piece, chk_x, chk_y,
    output chk_ack, chk_collide
  );
endinterface

// File: rtl/piece_spawn_ctrl.sv
// Tetromino spawn controller: LFSR piece draw, one-deep preview, spawn-point
// collision check against the board, and the sticky game_over flag.
module piece_spawn_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0]  SPAWN_X   = 4'd3,
  parameter logic [4:0]  SPAWN_Y   = 5'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    state,
  input  logic          piece_locked,
  piece_spawn_if.master chk,
  output logic          spawn_valid,
  output logic [2:0]    cur_piece,
  output logic [2:0]    next_piece,
  output logic          game_over,
  output logic [15:0]   pieces_spawned
);

  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS    = 16'hB400;  // x^16+x^14+x^13+x^11, right-shifting Galois
  localparam logic [1:0]  ST_PLAY = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_CHECK,
    S_ACTIVE,
    S_OVER
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  draw;
  logic [2:0]  cur_q, cur_d;
  logic [2:0]  next_q, next_d;
  logic [2:0]  cpiece_q, cpiece_d;
  logic        req_q, req_d;
  logic        sv_q, sv_d;
  logic        go_q, go_d;
  logic [15:0] spawn_cnt, cnt_d;
  logic        play, ack_ok, lock_ok;

  // Free-running LFSR; a 3-bit field of 7 is rejected, falling back to the next field, then to piece 0.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    if (lfsr_q[2:0] != 3'd7)      draw = lfsr_q[2:0];
    else if (lfsr_q[5:3] != 3'd7) draw = lfsr_q[5:3];
    else                          draw = 3'd0;
  end

  assign play    = (state == ST_PLAY);
  // An ack only counts once the request is actually visible on the bus.
  assign ack_ok  = (fsm_q == S_CHECK) && req_q && chk.chk_ack;
  // The spawn_valid cycle still belongs to the previous placement, so locks there are dropped.
  assign lock_ok = (fsm_q == S_ACTIVE) && !sv_q && piece_locked;

  always_comb begin
    fsm_d    = fsm_q;
    cur_d    = cur_q;
    next_d   = next_q;
    cpiece_d = cpiece_q;
    req_d    = 1'b0;
    sv_d     = 1'b0;
    go_d     = go_q;
    cnt_d    = spawn_cnt;
    case (fsm_q)
      S_IDLE: begin
        if (play) begin
          fsm_d  = S_PRIME;
          next_d = draw;
        end
      end
      S_PRIME: begin
        if (!play) begin
          fsm_d = S_IDLE;
        end else begin
          fsm_d  = S_CHECK;
          cur_d  = next_q;
          next_d = draw;
        end
      end
      S_CHECK: begin
        if (!play) begin
          fsm_d = S_IDLE;
        end else if (ack_ok) begin
          if (chk.chk_collide) begin
            fsm_d = S_OVER;
            go_d  = 1'b1;
          end else begin
            fsm_d = S_ACTIVE;
            sv_d  = 1'b1;
            if (spawn_cnt != 16'hFFFF) cnt_d = spawn_cnt + 16'd1;
          end
        end else begin
          req_d    = 1'b1;
          cpiece_d = cur_q;
        end
      end
      S_ACTIVE: begin
        if (!play) begin
          fsm_d = S_IDLE;
        end else if (lock_ok) begin
          fsm_d  = S_CHECK;
          cur_d  = next_q;
          next_d = draw;
        end
      end
      S_OVER: begin
        go_d = 1'b1;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= S_IDLE;
      lfsr_q    <= SEED;
      cur_q     <= 3'd0;
      next_q    <= 3'd0;
      cpiece_q  <= 3'd0;
      req_q     <= 1'b0;
      sv_q      <= 1'b0;
      go_q      <= 1'b0;
      spawn_cnt <= 16'h0000;
    end else begin
      fsm_q     <= fsm_d;
      lfsr_q    <= lfsr_d;
      cur_q     <= cur_d;
      next_q    <= next_d;
      cpiece_q  <= cpiece_d;
      req_q     <= req_d;
      sv_q      <= sv_d;
      go_q      <= go_d;
      spawn_cnt <= cnt_d;
    end
  end

  assign chk.chk_req     = req_q;
  assign chk.chk_piece   = cpiece_q;
  assign chk.chk_x       = SPAWN_X;
  assign chk.chk_y       = SPAWN_Y;
  assign spawn_valid     = sv_q;
  assign cur_piece       = cur_q;
  assign next_piece      = next_q;
  assign game_over       = go_q;
  assign pieces_spawned  = spawn_cnt;

endmodule

// File: tb/tb_piece_spawn_ctrl.sv
// Directed bench for piece_spawn_ctrl: stimulus pushes expected requests/spawns, a monitor pops and checks.
module tb_piece_spawn_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic        piece_locked;
  logic        spawn_valid;
  logic [2:0]  cur_piece, next_piece;
  logic        game_over;
  logic [15:0] pieces_spawned;

  piece_spawn_if ifc ();

  piece_spawn_ctrl #(.LFSR_SEED(16'hACE1), .SPAWN_X(4'd3), .SPAWN_Y(5'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .piece_locked   (piece_locked),
    .chk            (ifc.master),
    .spawn_valid    (spawn_valid),
    .cur_piece      (cur_piece),
    .next_piece     (next_piece),
    .game_over      (game_over),
    .pieces_spawned (pieces_spawned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cur;
    logic [2:0]  nxt;
    logic [15:0] cnt;
  } spawn_t;

  logic [2:0] exp_chk[$];
  spawn_t     exp_spawn[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference LFSR, stepped on the same edges as the design.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [2:0] draw_of(input logic [15:0] l);
    if (l[2:0] < 3'd7)      return l[2:0];
    else if (l[5:3] < 3'd7) return l[5:3];
    else                    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every new request and every spawn pulse must match the head of its queue.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.chk_req && !prev_req) begin
        if (exp_chk.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_chk_req: got request piece %0d, expected no request", ifc.chk_piece);
        end else begin
          automatic logic [2:0] e = exp_chk.pop_front();
          check("chk_piece", ifc.chk_piece, e);
          check("chk_x", ifc.chk_x, 4'd3);
          check("chk_y", ifc.chk_y, 5'd0);
        end
      end
      if (spawn_valid) begin
        if (exp_spawn.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_spawn: got spawn_valid cur %0d, expected none", cur_piece);
        end else begin
          automatic spawn_t s = exp_spawn.pop_front();
          check("spawn_cur", cur_piece, s.cur);
          check("spawn_next", next_piece, s.nxt);
          check("spawn_count", pieces_spawned, s.cnt);
          check("spawn_id_range", cur_piece <= 3'd6, 1'b1);
        end
      end
    end
    prev_req = ifc.chk_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  d0, d1, d, exp_next;
    logic [15:0] cnt;
    reset = 1'b1; state = 2'b00; piece_locked = 1'b0;
    ifc.chk_ack = 1'b0; ifc.chk_collide = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // 1: idle after reset
    repeat (5) tick();
    check("rst_chk_req", ifc.chk_req, 1'b0);
    check("rst_game_over", game_over, 1'b0);
    check("rst_count", pieces_spawned, 16'd0);
    check("rst_next", next_piece, 3'd0);
    check("rst_spawn_valid", spawn_valid, 1'b0);

    // 2: first request and its latency; an early ack while chk_req=0 is ignored
    d0 = draw_of(m_lfsr); state = 2'b01; tick();
    check("prime_next", next_piece, d0);
    check("prime_req", ifc.chk_req, 1'b0);
    d1 = draw_of(m_lfsr); exp_chk.push_back(d0); tick();
    check("check_req_lag", ifc.chk_req, 1'b0);
    check("check_cur", cur_piece, d0);
    check("check_next", next_piece, d1);
    ifc.chk_ack = 1'b1; tick(); ifc.chk_ack = 1'b0;
    check("req_after_2", ifc.chk_req, 1'b1);
    check("early_ack_no_spawn", spawn_valid, 1'b0);
    check("early_ack_count", pieces_spawned, 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_req", ifc.chk_req, 1'b1);
      check("hold_piece", ifc.chk_piece, d0);
    end

    // 3: clean spawn, then three lock/ack rounds
    exp_spawn.push_back('{cur: d0, nxt: d1, cnt: 16'd1});
    ifc.chk_ack = 1'b1; tick(); ifc.chk_ack = 1'b0;
    tick();
    check("spawn_one_cycle", spawn_valid, 1'b0);
    check("req_dropped", ifc.chk_req, 1'b0);
    exp_next = d1; cnt = 16'd1;
    for (int r = 0; r < 3; r++) begin
      d = draw_of(m_lfsr); piece_locked = 1'b1; tick(); piece_locked = 1'b0;
      exp_chk.push_back(exp_next); tick();
      cnt++; exp_spawn.push_back('{cur: exp_next, nxt: d, cnt: cnt});
      ifc.chk_ack = 1'b1; tick(); ifc.chk_ack = 1'b0;
      exp_next = d; tick();
    end
    check("count_4", pieces_spawned, 16'd4);

    // 4: colliding spawn -> sticky game_over
    piece_locked = 1'b1; tick(); piece_locked = 1'b0;
    exp_chk.push_back(exp_next); tick();
    ifc.chk_ack = 1'b1; ifc.chk_collide = 1'b1; tick();
    ifc.chk_ack = 1'b0; ifc.chk_collide = 1'b0;
    check("over_set", game_over, 1'b1);
    check("over_no_spawn", spawn_valid, 1'b0);
    for (int i = 0; i < 20; i++) begin
      piece_locked = i[0]; ifc.chk_ack = 1'b1;
      tick();
      check("over_held", game_over, 1'b1);
      check("over_no_req", ifc.chk_req, 1'b0);
      check("over_count", pieces_spawned, 16'd4);
    end
    piece_locked = 1'b0; ifc.chk_ack = 1'b0;
    reset = 1'b1; state = 2'b00; tick(); reset = 1'b0;
    check("reset_clears_over", game_over, 1'b0);
    check("reset_clears_count", pieces_spawned, 16'd0);

    // 5: locks in IDLE, PRIME and during the spawn pulse are ignored
    piece_locked = 1'b1; tick(); piece_locked = 1'b0; tick();
    check("idle_lock_req", ifc.chk_req, 1'b0);
    check("idle_lock_next", next_piece, 3'd0);
    d0 = draw_of(m_lfsr); state = 2'b01; tick();
    piece_locked = 1'b1; d1 = draw_of(m_lfsr); exp_chk.push_back(d0); tick();
    piece_locked = 1'b0;
    check("prime_lock_cur", cur_piece, d0);
    check("prime_lock_next", next_piece, d1);
    tick();
    exp_spawn.push_back('{cur: d0, nxt: d1, cnt: 16'd1});
    ifc.chk_ack = 1'b1; tick(); ifc.chk_ack = 1'b0;
    piece_locked = 1'b1; tick(); piece_locked = 1'b0;
    repeat (3) tick();
    check("sv_lock_req", ifc.chk_req, 1'b0);
    check("sv_lock_cur", cur_piece, d0);
    check("sv_lock_count", pieces_spawned, 16'd1);

    // 6: leaving PLAY while an ack arrives abandons the check
    d = draw_of(m_lfsr); piece_locked = 1'b1; tick(); piece_locked = 1'b0;
    exp_chk.push_back(d1); tick();
    state = 2'b00; ifc.chk_ack = 1'b1; tick(); ifc.chk_ack = 1'b0;
    check("abort_req", ifc.chk_req, 1'b0);
    check("abort_no_spawn", spawn_valid, 1'b0);
    check("abort_count", pieces_spawned, 16'd1);
    check("abort_cur", cur_piece, d1);
    check("abort_next", next_piece, d);
    tick();
    check("abort_no_spawn_late", spawn_valid, 1'b0);

    // saturation of the spawn counter
    force dut.spawn_cnt = 16'hFFFF; tick();
    release dut.spawn_cnt; tick();
    check("forced_count", pieces_spawned, 16'hFFFF);
    d0 = draw_of(m_lfsr); state = 2'b01; tick();
    d1 = draw_of(m_lfsr); exp_chk.push_back(d0); tick();
    tick();
    exp_spawn.push_back('{cur: d0, nxt: d1, cnt: 16'hFFFF});
    ifc.chk_ack = 1'b1; tick(); ifc.chk_ack = 1'b0;
    tick();
    check("sat_count", pieces_spawned, 16'hFFFF);

    repeat (3) tick();
    check("chk_queue_drained", exp_chk.size(), 16'd0);
    check("spawn_queue_drained", exp_spawn.size(), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
